cnn_layer_accel_trans_eg_serializer: RTL and testbench
======================================================

CNN_LAYER_ACCEL_TRANS_EG_SERIALIZER -- requirements
Module: cnn_layer_accel_trans_eg_serializer

Interface
REQ-001 SHALL have parameter C_META_WTH, default 64: FIFO metadata width.
REQ-002 SHALL have parameter C_PYLD_WTH, default 1024: FIFO payload width.
REQ-003 SHALL have parameter C_BEAT_WTH, default 256: output beat width. C_PYLD_WTH SHALL be a multiple of C_BEAT_WTH. NBEATS = C_PYLD_WTH/C_BEAT_WTH (default 4).
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: asynchronous assert, active-low reset.
REQ-005 SHALL have these FIFO-side ports:
- fifo_dout  in  C_META_WTH+C_PYLD_WTH: FIFO entry, meta in the upper bits, payload in the lower bits.
- fifo_empty  in  1: FIFO empty.
- fifo_valid  in  1: fifo_dout valid. Asserted exactly one cycle after an accepted fifo_rd_en.
- fifo_rd_rst_busy  in  1: FIFO read side is in reset.
- fifo_rd_en  out  1: pop request.
REQ-006 SHALL have these stream and status ports:
- m_data  out  C_BEAT_WTH: output beat.
- m_valid  out  1: beat valid.
- m_last  out  1: final beat of the packet.
- m_ready  in  1: downstream accept.
- pkt_cnt  out  32: packets completed.
- err  out  1: sticky protocol/format error.

Function
REQ-007 SHALL implement the FSM states IDLE, WAIT, HDR and PYLD.
REQ-008 IDLE: SHALL drive fifo_rd_en=1 combinationally when fifo_empty=0 and fifo_rd_rst_busy=0, then go to WAIT. fifo_rd_en SHALL be 0 in every other state and condition.
REQ-009 WAIT: on fifo_valid=1 SHALL capture meta and payload into registers, load beat_idx=0, and go to HDR. Otherwise SHALL remain in WAIT.
REQ-010 Beat count field: bc = meta[2:0].
- bc=0: header-only packet.
- bc 1..NBEATS: that many payload beats.
- bc>NBEATS: SHALL be treated as NBEATS and SHALL set err.
REQ-011 HDR: SHALL drive m_valid=1 and m_data = captured meta, zero-extended to C_BEAT_WTH. m_last SHALL equal (bc==0).
REQ-012 HDR on m_valid&&m_ready:
- bc==0: SHALL go to IDLE.
- otherwise: SHALL go to PYLD.
REQ-013 PYLD: SHALL drive m_valid=1 and m_data = payload[beat_idx*C_BEAT_WTH +: C_BEAT_WTH], beat 0 being the least significant. m_last SHALL equal (beat_idx == effective_bc-1).
REQ-014 PYLD on m_valid&&m_ready: SHALL increment beat_idx. On the last beat SHALL go to IDLE.
REQ-015 While m_valid=1 and m_ready=0, m_data, m_last and m_valid SHALL hold stable. Valid SHALL never be deasserted before acceptance.
REQ-016 pkt_cnt SHALL increment by 1 on each accepted beat with m_last=1, and SHALL wrap modulo 2^32.
REQ-017 fifo_valid=1 in IDLE, HDR or PYLD SHALL set err and SHALL be otherwise ignored (no capture).
REQ-018 err SHALL be sticky until reset.
REQ-019 Latency:
- fifo_rd_en at cycle T, fifo_valid at T+1, header m_valid at T+2.
- Minimum packet period is 3 + effective_bc cycles with m_ready held 1.
REQ-020 No simultaneous pop with output: a new pop SHALL issue only from IDLE, after the previous m_last is accepted.
REQ-021 fifo_rd_rst_busy=1 while in IDLE SHALL block pops. In other states it SHALL have no effect.

Reset
REQ-022 rst_n=0 SHALL immediately (asynchronously) force:
- state=IDLE, beat_idx=0
- m_valid=0, m_last=0, m_data=0
- pkt_cnt=0, err=0
- captured registers=0
- fifo_rd_en=0
REQ-023 Reset mid-packet SHALL abandon the packet with no partial completion counted. The first post-reset action SHALL be a fresh pop from IDLE.
REQ-024 Release of rst_n SHALL be sampled synchronously to clk. No pop SHALL occur in the cycle rst_n deasserts.

Verification
REQ-025 Entry with meta=0x...0004 and payload beats P0..P3, m_ready=1 -> fifo_rd_en at T; at T+2..T+6: header 0x4, then P0, P1, P2, P3 with m_last on P3; pkt_cnt=1, err=0.
REQ-026 meta bc=0 -> single header beat with m_last=1, no payload beats, pkt_cnt+1.
REQ-027 meta bc=7 -> header plus 4 payload beats, err=1 and remains 1 across later good packets.
REQ-028 m_ready toggled pseudo-randomly over 3 back-to-back entries -> every beat held stable while stalled, beat order and m_last correct, pkt_cnt=3, no extra fifo_rd_en pulses.
REQ-029 rst_n asserted during PYLD beat 2 -> outputs zero immediately; pkt_cnt stays 0; after release, next entry is popped and streamed from its header.
REQ-030 fifo_rd_rst_busy=1 with fifo_empty=0 -> no fifo_rd_en; fifo_valid pulse injected in IDLE -> err=1, no output beat.

Source files
------------

// File: rtl/cnn_layer_accel_trans_eg_serializer.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_trans_eg_serializer
//
// Purpose:
//   Pops one entry (metadata + payload) at a time from a FIFO. Each entry is
//   sent out as a stream packet: first a header beat that carries the
//   metadata, then 0..NBEATS payload beats, least significant beat first. The
//   beat count comes from meta[2:0]. A count above NBEATS is clamped to NBEATS
//   and flags an error. The block counts completed packets and keeps a sticky
//   protocol/format error flag.
//
// Ports:
//   clk              in   sole clock, rising edge
//   rst_n            in   asynchronous assert, active-low reset
//   fifo_dout        in   FIFO entry {meta, payload}
//   fifo_empty       in   FIFO empty
//   fifo_valid       in   fifo_dout valid, one cycle after an accepted pop
//   fifo_rd_rst_busy in   FIFO read side in reset; blocks pops from IDLE
//   fifo_rd_en       out  pop request (combinational, IDLE only)
//   m_data           out  output beat
//   m_valid          out  beat valid
//   m_last           out  final beat of the packet
//   m_ready          in   downstream accept
//   pkt_cnt          out  completed packets, wraps modulo 2^32
//   err              out  sticky protocol/format error
// -----------------------------------------------------------------------------
module cnn_layer_accel_trans_eg_serializer #(
   parameter int C_META_WTH = 64,
   parameter int C_PYLD_WTH = 1024,
   parameter int C_BEAT_WTH = 256
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [C_META_WTH+C_PYLD_WTH-1:0] fifo_dout,
   input  logic                             fifo_empty,
   input  logic                             fifo_valid,
   input  logic                             fifo_rd_rst_busy,
   output logic                             fifo_rd_en,
   output logic [C_BEAT_WTH-1:0]            m_data,
   output logic                             m_valid,
   output logic                             m_last,
   input  logic                             m_ready,
   output logic [31:0]                      pkt_cnt,
   output logic                             err
);

   localparam int NBEATS = C_PYLD_WTH / C_BEAT_WTH;
   localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HDR  = 2'd2;
   localparam logic [1:0] S_PYLD = 2'd3;

   logic [1:0]            state_q,    state_d;
   logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
   logic [C_META_WTH-1:0] meta_q,     meta_d;
   logic [C_PYLD_WTH-1:0] pyld_q,     pyld_d;
   logic [31:0]           pkt_cnt_q,  pkt_cnt_d;
   logic                  err_q,      err_d;
   // Cleared by reset and set on the first clock edge after release. Without
   // it, the combinational pop could fire in the cycle rst_n deasserts.
   logic                  armed_q;

   logic [2:0]            bc_raw;
   logic [2:0]            bc_in;
   logic [IDX_W-1:0]      last_idx;
   logic [C_BEAT_WTH-1:0] beat_sel;
   logic                  accept;

   assign bc_raw = meta_q[2:0];
   assign bc_in  = fifo_dout[C_PYLD_WTH +: 3];
   assign accept = m_valid & m_ready;

   // Index of the final payload beat. Counts above NBEATS are clamped.
   // bc==0 never reaches PYLD, so the wrap of bc-1 is harmless.
   always_comb begin
      if (32'(bc_raw) > 32'(NBEATS)) begin
         last_idx = IDX_W'(NBEATS - 1);
      end else begin
         last_idx = IDX_W'(32'(bc_raw) - 32'd1);
      end
   end

   always_comb begin
      beat_sel = '0;
      for (int i = 0; i < NBEATS; i++) begin
         if (beat_idx_q == IDX_W'(i)) begin
            beat_sel = pyld_q[i*C_BEAT_WTH +: C_BEAT_WTH];
         end
      end
   end

   // Outputs are decoded from registered state only. They stay stable while
   // the downstream stalls, and they drop to zero as soon as reset asserts.
   always_comb begin
      fifo_rd_en = 1'b0;
      m_valid    = 1'b0;
      m_last     = 1'b0;
      m_data     = '0;
      case (state_q)
         S_IDLE: fifo_rd_en = armed_q & ~fifo_empty & ~fifo_rd_rst_busy;
         S_HDR: begin
            m_valid = 1'b1;
            m_data  = C_BEAT_WTH'(meta_q);
            m_last  = (bc_raw == 3'd0);
         end
         S_PYLD: begin
            m_valid = 1'b1;
            m_data  = beat_sel;
            m_last  = (beat_idx_q == last_idx);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      beat_idx_d = beat_idx_q;
      meta_d     = meta_q;
      pyld_d     = pyld_q;
      pkt_cnt_d  = pkt_cnt_q;
      err_d      = err_q;

      if (accept && m_last) begin
         pkt_cnt_d = pkt_cnt_q + 32'd1;
      end

      // A data-valid strobe that was not requested is flagged and dropped.
      if (fifo_valid && (state_q != S_WAIT)) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (fifo_rd_en) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (fifo_valid) begin
               meta_d     = fifo_dout[C_PYLD_WTH +: C_META_WTH];
               pyld_d     = fifo_dout[C_PYLD_WTH-1:0];
               beat_idx_d = '0;
               state_d    = S_HDR;
               if (32'(bc_in) > 32'(NBEATS)) begin
                  err_d = 1'b1;
               end
            end
         end
         S_HDR: begin
            if (accept) begin
               state_d = (bc_raw == 3'd0) ? S_IDLE : S_PYLD;
            end
         end
         S_PYLD: begin
            if (accept) begin
               beat_idx_d = beat_idx_q + IDX_W'(1);
               if (m_last) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         beat_idx_q <= '0;
         meta_q     <= '0;
         pyld_q     <= '0;
         pkt_cnt_q  <= '0;
         err_q      <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_idx_q <= beat_idx_d;
         meta_q     <= meta_d;
         pyld_q     <= pyld_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_q      <= err_d;
         armed_q    <= 1'b1;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err     = err_q;

endmodule

// File: tb/tb_cnn_layer_accel_trans_eg_serializer.sv
// -----------------------------------------------------------------------------
// tb_cnn_layer_accel_trans_eg_serializer
//
// Directed bench for the FIFO-to-stream serializer. A small FIFO model feeds
// the DUT. Expected beats are queued when an entry is written into the FIFO
// model, and each accepted output beat is popped from that queue and compared.
// -----------------------------------------------------------------------------
module tb_cnn_layer_accel_trans_eg_serializer;

   localparam int MW = 16;
   localparam int PW = 128;
   localparam int BW = 32;
   localparam int NB = PW / BW;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [MW+PW-1:0]  fifo_dout;
   logic              fifo_empty;
   logic              fifo_valid;
   logic              fifo_rd_rst_busy;
   logic              fifo_rd_en;
   logic [BW-1:0]     m_data;
   logic              m_valid;
   logic              m_last;
   logic              m_ready;
   logic [31:0]       pkt_cnt;
   logic              err;

   always #5 clk = ~clk;

   cnn_layer_accel_trans_eg_serializer #(
      .C_META_WTH(MW),
      .C_PYLD_WTH(PW),
      .C_BEAT_WTH(BW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fifo_dout        (fifo_dout),
      .fifo_empty       (fifo_empty),
      .fifo_valid       (fifo_valid),
      .fifo_rd_rst_busy (fifo_rd_rst_busy),
      .fifo_rd_en       (fifo_rd_en),
      .m_data           (m_data),
      .m_valid          (m_valid),
      .m_last           (m_last),
      .m_ready          (m_ready),
      .pkt_cnt          (pkt_cnt),
      .err              (err)
   );

   typedef struct packed {
      logic [BW-1:0] data;
      logic          last;
      logic          hdr;
   } beat_t;

   beat_t            exp_q[$];
   logic [MW+PW-1:0] fq[$];

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            pops = 0;
   int            acc_beats = 0;
   int            rd_cyc = 0;
   int            hdr_cyc = 0;
   int            last_cyc = 0;
   logic          rd_at_neg = 1'b0;
   logic          inject = 1'b0;
   logic          rnd_ready = 1'b0;
   logic [MW+PW-1:0] inj_word = '0;
   logic          prev_stall = 1'b0;
   logic [BW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] pbeat(input logic [MW-1:0] meta, input int i);
      return {16'hB000 + 16'(i), meta};
   endfunction

   // Writes one entry into the FIFO model and queues the beats it must produce.
   task automatic push_entry(input logic [MW-1:0] meta);
      logic [PW-1:0] p;
      beat_t         b;
      int            bc;
      int            eff;
      p = '0;
      for (int i = 0; i < NB; i++) p[i*BW +: BW] = pbeat(meta, i);
      fq.push_back({meta, p});
      fifo_empty = 1'b0;
      bc  = int'(meta[2:0]);
      eff = (bc > NB) ? NB : bc;
      b.data = BW'(meta);
      b.last = (bc == 0);
      b.hdr  = 1'b1;
      exp_q.push_back(b);
      for (int i = 0; i < eff; i++) begin
         b.data = pbeat(meta, i);
         b.last = (i == eff - 1);
         b.hdr  = 1'b0;
         exp_q.push_back(b);
      end
   endtask

   // One clock: sample and score at the falling edge, then update the FIFO
   // model and m_ready just after the rising edge.
   task automatic cycle();
      beat_t e;
      @(negedge clk);
      cyc++;
      rd_at_neg = fifo_rd_en;
      if (fifo_rd_en) begin
         pops++;
         rd_cyc = cyc;
      end
      if (prev_stall) begin
         chk("hold_valid", 64'(m_valid), 64'd1);
         chk("hold_data", 64'(m_data), 64'(prev_data));
         chk("hold_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            chk("beat_expected", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(m_data), 64'(e.data));
            chk("beat_last", 64'(m_last), 64'(e.last));
            acc_beats++;
            if (e.hdr) hdr_cyc = cyc;
            if (m_last) last_cyc = cyc;
         end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      @(posedge clk);
      #1;
      if (rd_at_neg && (fq.size() > 0)) begin
         fifo_dout  = fq.pop_front();
         fifo_valid = 1'b1;
      end else if (inject) begin
         fifo_dout  = inj_word;
         fifo_valid = 1'b1;
      end else begin
         fifo_valid = 1'b0;
      end
      inject     = 1'b0;
      fifo_empty = (fq.size() == 0);
      m_ready    = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while (((exp_q.size() != 0) || (fq.size() != 0)) && (n < maxc)) begin
         cycle();
         n++;
      end
      chk("drain_in_time", 64'(exp_q.size()), 64'd0);
      cycle();
      cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int a0;
      int n;

      rst_n            = 1'b0;
      fifo_dout        = '0;
      fifo_empty       = 1'b1;
      fifo_valid       = 1'b0;
      fifo_rd_rst_busy = 1'b0;
      m_ready          = 1'b1;
      repeat (3) cycle();

      // Reset state.
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);

      // Basic 4-beat packet, with the FIFO already non-empty at release.
      push_entry(16'h0004);
      rst_n = 1'b1;
      cycle();
      chk("no_pop_at_release", 64'(rd_at_neg), 64'd0);
      p0 = pops;
      drain(40);
      chk("basic_pops", 64'(pops - p0), 64'd1);
      chk("lat_hdr", 64'(hdr_cyc - rd_cyc), 64'd2);
      chk("lat_last", 64'(last_cyc - rd_cyc), 64'd6);
      chk("basic_pkt_cnt", 64'(pkt_cnt), 64'd1);
      chk("basic_err", 64'(err), 64'd0);

      // Header-only packet.
      push_entry(16'h0120);
      drain(40);
      chk("hdr_only_pkt_cnt", 64'(pkt_cnt), 64'd2);
      chk("hdr_only_err", 64'(err), 64'd0);

      // Oversized beat count, then a good packet: err stays set.
      push_entry(16'h00A7);
      drain(40);
      chk("bc7_err", 64'(err), 64'd1);
      chk("bc7_pkt_cnt", 64'(pkt_cnt), 64'd3);
      push_entry(16'h0032);
      drain(40);
      chk("sticky_err", 64'(err), 64'd1);
      chk("after_bc7_pkt_cnt", 64'(pkt_cnt), 64'd4);

      // Three back-to-back entries with a randomly stalling downstream.
      p0 = pops;
      rnd_ready = 1'b1;
      push_entry(16'h0044);
      push_entry(16'h0053);
      push_entry(16'h0061);
      drain(300);
      rnd_ready = 1'b0;
      cycle();
      chk("stall_pops", 64'(pops - p0), 64'd3);
      chk("stall_pkt_cnt", 64'(pkt_cnt), 64'd7);

      // Reset clears counters and the sticky error at once.
      rst_n = 1'b0;
      #1;
      chk("rst2_err", 64'(err), 64'd0);
      chk("rst2_pkt_cnt", 64'(pkt_cnt), 64'd0);
      cycle();
      rst_n = 1'b1;
      cycle();
      cycle();

      // Reset while payload beat 2 is on the output.
      push_entry(16'h0074);
      a0 = acc_beats;
      n  = 0;
      while (((acc_beats - a0) < 3) && (n < 30)) begin
         cycle();
         n++;
      end
      chk("reach_beat2", 64'(acc_beats - a0), 64'd3);
      chk("beat2_presented", 64'(m_data), 64'(exp_q[0].data));
      rst_n = 1'b0;
      #1;
      chk("midrst_m_valid", 64'(m_valid), 64'd0);
      chk("midrst_m_data", 64'(m_data), 64'd0);
      chk("midrst_m_last", 64'(m_last), 64'd0);
      chk("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
      exp_q.delete();
      push_entry(16'h0083);
      cycle();
      cycle();
      chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      p0 = pops;
      rst_n = 1'b1;
      cycle();
      chk("no_pop_at_release2", 64'(rd_at_neg), 64'd0);
      drain(40);
      chk("post_rst_pops", 64'(pops - p0), 64'd1);
      chk("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd1);

      // FIFO read side busy blocks pops; a stray valid in IDLE flags err.
      fifo_rd_rst_busy = 1'b1;
      p0 = pops;
      push_entry(16'h0092);
      repeat (5) cycle();
      chk("busy_no_pop", 64'(pops - p0), 64'd0);
      chk("busy_err_clear", 64'(err), 64'd0);
      inj_word = {16'h0002, {(PW/16){16'hDEAD}}};
      inject   = 1'b1;
      repeat (3) cycle();
      chk("stray_valid_err", 64'(err), 64'd1);
      chk("stray_no_output", 64'(m_valid), 64'd0);
      chk("stray_no_beat", 64'(exp_q.size()), 64'd3);
      fifo_rd_rst_busy = 1'b0;
      drain(40);
      chk("unbusy_pops", 64'(pops - p0), 64'd1);
      chk("unbusy_pkt_cnt", 64'(pkt_cnt), 64'd2);
      chk("unbusy_err", 64'(err), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
